// File: rtl/pll_sup_pkg.sv
// Shared state encoding and constants for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } pll_sup_state_t;

    localparam int RETRY_W = 8;

    // Saturating increment used by the status counters.
    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        return (v == {RETRY_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies lock and releases sys_reset; recovers from lock loss.
// Optional retry limit with FAIL state: define PLL_SUP_RETRY_LIMIT_EN.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 33554,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_lock,
    input  logic               clr_status,
    output logic               pll_reset,
    output logic               sys_reset,
    output logic               locked,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic               fail
);

    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD  = (STABLE_CYCLES > MAX_RETRIES) ? STABLE_CYCLES : MAX_RETRIES;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    // The counter runs from N-1 down to 0, so N-1 always fits in CNT_W bits.
    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);

    pll_sup_state_t   state;
    pll_sup_state_t   next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load;
    logic             lock_s;
    logic             timeout;
    logic             lost;
    logic             pll_reset_d;
    logic             sys_reset_d;
    logic             locked_d;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

`ifdef PLL_SUP_RETRY_LIMIT_EN
    localparam logic [RETRY_W:0] RETRY_LIMIT = (RETRY_W+1)'(MAX_RETRIES);

    // Attempt count is private so clr_status cannot extend the retry budget.
    logic [RETRY_W-1:0] attempts;
    logic [RETRY_W:0]   attempts_plus;
    logic               limit_hit;

    assign attempts_plus = {1'b0, attempts} + (RETRY_W+1)'(1);
    assign limit_hit     = attempts_plus > RETRY_LIMIT;
`endif

    always_comb begin
        next_state = state;
        timeout    = 1'b0;
        lost       = 1'b0;
        case (state)
            PLL_RST: begin
                if (cnt == '0) begin
                    next_state = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    next_state = STABLE;
                end else if (cnt == '0) begin
                    timeout = 1'b1;
`ifdef PLL_SUP_RETRY_LIMIT_EN
                    next_state = limit_hit ? FAIL : PLL_RST;
`else
                    next_state = PLL_RST;
`endif
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    next_state = WAIT_LOCK;
                end else if (cnt == '0) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    lost       = 1'b1;
                    next_state = PLL_RST;
                end
            end
`ifdef PLL_SUP_RETRY_LIMIT_EN
            FAIL: begin
                next_state = FAIL;
            end
`endif
            default: begin
                next_state = PLL_RST;
            end
        endcase
    end

    always_comb begin
        cnt_load = '0;
        case (next_state)
            PLL_RST:   cnt_load = RST_LOAD;
            WAIT_LOCK: cnt_load = WAIT_LOAD;
            STABLE:    cnt_load = STABLE_LOAD;
            default:   cnt_load = '0;
        endcase
    end

    // Outputs are decoded from next_state so they flip on the same edge as the state.
    always_comb begin
        pll_reset_d = 1'b0;
        sys_reset_d = 1'b1;
        locked_d    = 1'b0;
        case (next_state)
            PLL_RST: begin
                pll_reset_d = 1'b1;
            end
            RUN: begin
                sys_reset_d = 1'b0;
                locked_d    = 1'b1;
            end
`ifdef PLL_SUP_RETRY_LIMIT_EN
            FAIL: begin
                pll_reset_d = 1'b1;
            end
`endif
            default: begin
                pll_reset_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PLL_RST;
            cnt       <= RST_LOAD;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
            retry_cnt <= '0;
        end else begin
            state     <= next_state;
            pll_reset <= pll_reset_d;
            sys_reset <= sys_reset_d;
            locked    <= locked_d;

            if (next_state != state) begin
                cnt <= cnt_load;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            // A set or increment on the same cycle as clr_status takes priority.
            if (lost) begin
                lock_lost <= 1'b1;
            end else if (clr_status) begin
                lock_lost <= 1'b0;
            end

            if (timeout) begin
                retry_cnt <= sat_inc(retry_cnt);
            end else if (clr_status) begin
                retry_cnt <= '0;
            end
        end
    end

`ifdef PLL_SUP_RETRY_LIMIT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            attempts <= '0;
            fail     <= 1'b0;
        end else begin
            fail <= (next_state == FAIL);
            if (timeout) begin
                attempts <= sat_inc(attempts);
            end
        end
    end
`else
    assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios with literal
// expectations plus randomized lock/clear/reset traffic checked against a cycle model.
module tb_pll_lock_supervisor;

    localparam int T_RST    = 4;
    localparam int T_TO     = 20;
    localparam int T_STABLE = 8;
    localparam int T_MAXR   = 2;

    localparam int S_PLL_RESET = 0;
    localparam int S_SYS_RESET = 1;

    localparam int P_PULSE = 0;
    localparam int P_WAIT  = 1;
    localparam int P_QUAL  = 2;
    localparam int P_RUN   = 3;
    localparam int P_DEAD  = 4;

    logic       clk;
    logic       reset;
    logic       pll_lock;
    logic       clr_status;
    logic       pll_reset;
    logic       sys_reset;
    logic       locked;
    logic       lock_lost;
    logic [7:0] retry_cnt;
    logic       fail;

    int errors;
    int checks;

    pll_lock_supervisor #(
        .RST_CYCLES    (T_RST),
        .LOCK_TIMEOUT  (T_TO),
        .STABLE_CYCLES (T_STABLE),
        .MAX_RETRIES   (T_MAXR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .clr_status (clr_status),
        .pll_reset  (pll_reset),
        .sys_reset  (sys_reset),
        .locked     (locked),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt),
        .fail       (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase plus cycles-elapsed-in-phase, and a two-deep lock history.
    typedef struct packed {
        int   phase;
        int   elapsed;
        logic hist1;
        logic hist2;
        logic lost;
        int   retry;
        int   timeouts;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.phase    = P_PULSE;
        r.elapsed  = 0;
        r.hist1    = 1'b0;
        r.hist2    = 1'b0;
        r.lost     = 1'b0;
        r.retry    = 0;
        r.timeouts = 0;
        return r;
    endfunction

    function automatic model_t model_next(model_t cur, logic lock_pin, logic clr);
        model_t n;
        logic   seen;
        int     goto;
        n       = cur;
        seen    = cur.hist2;
        n.hist2 = cur.hist1;
        n.hist1 = lock_pin;
        goto    = -1;
        if (clr) begin
            n.lost  = 1'b0;
            n.retry = 0;
        end
        n.elapsed = cur.elapsed + 1;
        case (cur.phase)
            P_PULSE: if (n.elapsed == T_RST) goto = P_WAIT;
            P_WAIT: begin
                if (seen) begin
                    goto = P_QUAL;
                end else if (n.elapsed == T_TO) begin
                    n.retry    = (cur.retry >= 255) ? 255 : cur.retry + 1;
                    n.timeouts = cur.timeouts + 1;
                    goto       = P_PULSE;
`ifdef PLL_SUP_RETRY_LIMIT_EN
                    if (n.timeouts > T_MAXR) goto = P_DEAD;
`endif
                end
            end
            P_QUAL: begin
                if (!seen) goto = P_WAIT;
                else if (n.elapsed == T_STABLE) goto = P_RUN;
            end
            P_RUN: begin
                if (!seen) begin
                    n.lost = 1'b1;
                    goto   = P_PULSE;
                end
            end
            default: goto = -1;
        endcase
        if (goto >= 0) begin
            n.phase   = goto;
            n.elapsed = 0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= model_reset();
        else       m <= model_next(m, pll_lock, clr_status);
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        check_output("cmp_pll_reset", int'(pll_reset), int'(m.phase == P_PULSE || m.phase == P_DEAD));
        check_output("cmp_sys_reset", int'(sys_reset), int'(m.phase != P_RUN));
        check_output("cmp_locked",    int'(locked),    int'(m.phase == P_RUN));
        check_output("cmp_lock_lost", int'(lock_lost), int'(m.lost));
        check_output("cmp_retry_cnt", int'(retry_cnt), m.retry);
        check_output("cmp_fail",      int'(fail),      int'(m.phase == P_DEAD));
    end

    function automatic logic get_sig(input int sel);
        return (sel == S_PLL_RESET) ? pll_reset : sys_reset;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Counts edges until the selected output reaches val; ends 2 time units after an edge.
    task automatic wait_until(input int sel, input logic val, input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (get_sig(sel) != val && n < limit);
        check_output("wait_reached", int'(get_sig(sel)), int'(val));
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        pll_lock   = 1'b0;
        clr_status = 1'b0;
        wait_cycles(2);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int na;
        int nb;
        int run_left;
        errors     = 0;
        checks     = 0;
        reset      = 1'b1;
        pll_lock   = 1'b0;
        clr_status = 1'b0;

        @(posedge clk);
        #2;
        check_output("rst_pll_reset", int'(pll_reset), 1);
        check_output("rst_sys_reset", int'(sys_reset), 1);
        check_output("rst_locked",    int'(locked),    0);
        check_output("rst_retry_cnt", int'(retry_cnt), 0);
        check_output("rst_fail",      int'(fail),      0);
        wait_cycles(1);
        reset = 1'b0;

        // Clean bring-up
        $display("[TB] clean bring-up");
        wait_until(S_PLL_RESET, 1'b0, 40, n);
        check_output("bringup_rst_edges", n, 4);
        wait_cycles(1);
        pll_lock = 1'b1;
        wait_until(S_SYS_RESET, 1'b0, 60, n);
        check_output("bringup_release_edges", n, 11);
        check_output("bringup_locked", int'(locked), 1);
        check_output("bringup_retry", int'(retry_cnt), 0);

        // Lock loss in RUN, then clear the sticky flag
        $display("[TB] lock loss in RUN");
        pll_lock = 1'b0;
        wait_until(S_PLL_RESET, 1'b1, 20, n);
        check_output("loss_edges", n, 3);
        check_output("loss_sys_reset", int'(sys_reset), 1);
        check_output("loss_lock_lost", int'(lock_lost), 1);
        clr_status = 1'b1;
        wait_cycles(1);
        clr_status = 1'b0;
        check_output("clr_lock_lost", int'(lock_lost), 0);

        // Timeout retries with lock held low
        $display("[TB] timeout retry");
        wait_until(S_PLL_RESET, 1'b0, 20, n);
        wait_until(S_PLL_RESET, 1'b1, 40, n);
        check_output("timeout1_edges", n, 20);
        check_output("timeout1_retry", int'(retry_cnt), 1);
        wait_until(S_PLL_RESET, 1'b0, 20, na);
        wait_until(S_PLL_RESET, 1'b1, 40, nb);
        check_output("retry_period", na + nb, 24);
        check_output("timeout2_retry", int'(retry_cnt), 2);
        wait_until(S_PLL_RESET, 1'b0, 20, n);
        wait_until(S_PLL_RESET, 1'b1, 40, n);
        check_output("timeout3_edges", n, 20);
        check_output("timeout3_retry", int'(retry_cnt), 3);
`ifdef PLL_SUP_RETRY_LIMIT_EN
        check_output("limit_fail", int'(fail), 1);
        wait_cycles(30);
        check_output("limit_pll_reset_held", int'(pll_reset), 1);
        check_output("limit_fail_held", int'(fail), 1);
`else
        check_output("nolimit_fail", int'(fail), 0);
        wait_until(S_PLL_RESET, 1'b0, 20, n);
        check_output("nolimit_retry_continues", n, 4);
`endif

        // Unstable lock: short lock must not release, stable relock must
        $display("[TB] unstable lock");
        apply_reset();
        wait_until(S_PLL_RESET, 1'b0, 40, n);
        wait_cycles(1);
        pll_lock = 1'b1;
        wait_cycles(5);
        pll_lock = 1'b0;
        check_output("unstable_hold1", int'(sys_reset), 1);
        wait_cycles(4);
        check_output("unstable_hold2", int'(sys_reset), 1);
        pll_lock = 1'b1;
        wait_until(S_SYS_RESET, 1'b0, 60, n);
        check_output("unstable_release_edges", n, 11);
        check_output("unstable_retry", int'(retry_cnt), 0);

        // Async reset while qualifying lock
        $display("[TB] async reset mid-STABLE");
        pll_lock = 1'b0;
        wait_until(S_PLL_RESET, 1'b1, 20, n);
        pll_lock = 1'b1;
        wait_until(S_PLL_RESET, 1'b0, 20, n);
        wait_cycles(3);
        check_output("stable_pre_pll_reset", int'(pll_reset), 0);
        check_output("stable_pre_lock_lost", int'(lock_lost), 1);
        #1;
        reset = 1'b1;
        #1;
        check_output("async_pll_reset", int'(pll_reset), 1);
        check_output("async_sys_reset", int'(sys_reset), 1);
        check_output("async_locked",    int'(locked),    0);
        check_output("async_lock_lost", int'(lock_lost), 0);
        check_output("async_retry",     int'(retry_cnt), 0);
        wait_cycles(1);
        reset    = 1'b0;
        pll_lock = 1'b0;

        // Randomized traffic checked by the model every cycle
        $display("[TB] random traffic");
        run_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                pll_lock = ~pll_lock;
                run_left = pll_lock ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 30));
            end
            run_left--;
            clr_status = ($urandom_range(0, 29) == 0);
            reset      = ($urandom_range(0, 599) == 0);
            wait_cycles(1);
        end
        reset      = 1'b0;
        clr_status = 1'b0;
        wait_cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the clocking PLL out of reset and qualifies its `lock` output before releasing system reset to the core clock domains. It runs on the PLL reference clock, which is the 33.554 MHz oscillator. It drives the PLL `reset` input and consumes the PLL `lock` output, so it forms the other end of the PLL control interface. It recovers from lock loss by re-resetting the PLL and reports status to the ESP32 status registers.

## Interface
- `RST_CYCLES`, default 16: number of cycles `pll_reset` is held high per attempt.
- `LOCK_TIMEOUT`, default 33554: cycles to wait for lock before retrying (about 1 ms).
- `STABLE_CYCLES`, default 1024: consecutive locked cycles required before release.
- `MAX_RETRIES`, default 7: failed attempts allowed before `fail`. Used only with the macro.
- `clk`  in  1: PLL reference clock.
- `reset`  in  1: asynchronous, active-high.
- `pll_lock`  in  1: PLL lock output. Asynchronous to `clk`.
- `clr_status`  in  1: one-cycle pulse that clears `lock_lost` and `retry_cnt`.
- `pll_reset`  out  1: drives the PLL reset input.
- `sys_reset`  out  1: active-high reset for the downstream domains. Each domain synchronizes its own deassertion.
- `locked`  out  1: high only in RUN.
- `lock_lost`  out  1: sticky flag. Lock dropped while in RUN.
- `retry_cnt`  out  8: saturating count of lock timeouts.
- `fail`  out  1: retry limit exhausted.

## Operation
- `pll_lock` passes through a 2-flop synchronizer to give `lock_s`. All decisions use `lock_s`.
- One down-counter, `cnt`, is sized `$clog2` of the largest parameter. It is reloaded on every state entry.
- **PLL_RST**
  - `pll_reset`=1 and `sys_reset`=1.
  - After `RST_CYCLES` cycles, go to WAIT_LOCK.
- **WAIT_LOCK**
  - `pll_reset`=0 and `sys_reset`=1.
  - If `lock_s`=1, go to STABLE.
  - If `LOCK_TIMEOUT` cycles elapse with no lock, go to PLL_RST and increment `retry_cnt`. The increment saturates at 255.
- **STABLE**
  - `sys_reset`=1.
  - If `lock_s`=0, go to WAIT_LOCK. The counter reloads and `retry_cnt` is unchanged.
  - After `STABLE_CYCLES` consecutive cycles with `lock_s`=1, go to RUN.
- **RUN**
  - `sys_reset`=0 and `locked`=1.
  - If `lock_s`=0, go to PLL_RST and set `lock_lost`.
- **FAIL** (macro only)
  - `pll_reset`=1, `sys_reset`=1 and `fail`=1.
  - Terminal state. Leaves only on `reset`.
- If `clr_status` and a set or increment land on the same cycle, the set or increment wins.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state.

## Timing
- Reset values:
  - state = PLL_RST
  - `pll_reset`=1, `sys_reset`=1
  - `locked`=0, `lock_lost`=0, `retry_cnt`=0, `fail`=0
- After `reset` deasserts, `pll_reset` stays high for exactly `RST_CYCLES` edges.
- Lock rising at the pin to STABLE entry: 3 cycles (2 synchronizer + 1 state register).
- STABLE entry to `sys_reset` falling: `STABLE_CYCLES` cycles.
- Lock falling at the pin to `sys_reset` rising and `pll_reset` rising: 3 cycles. `lock_lost` sets on the same edge.
- A glitch shorter than one cycle may be missed. That is acceptable because the PLL holds `lock` low for many cycles on a real loss.
- `reset` asserted mid-operation immediately forces every output to its reset value. It is asynchronous, so it is not delayed by the synchronizer.

## Configuration
- `PLL_SUP_RETRY_LIMIT_EN` defined:
  - A WAIT_LOCK timeout that makes the attempt count exceed `MAX_RETRIES` goes to FAIL instead of PLL_RST.
  - `retry_cnt` still increments on that timeout.
- `PLL_SUP_RETRY_LIMIT_EN` undefined:
  - Retries continue forever.
  - `fail` is tied to 0 and the FAIL state is not compiled.

## Structure
- Shared package `pll_sup_pkg` holds:
  - the state enum `pll_sup_state_t` (PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL)
  - the `RETRY_W`=8 constant
- One natural sub-module: `sync_2ff`, the lock synchronizer. It has two flops with a reset value of 0, and it is reusable elsewhere.

## Test plan
Bench parameters: `RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8, `MAX_RETRIES`=2.

- **Clean bring-up.** Release `reset`, then raise `pll_lock` 2 cycles after `pll_reset` falls -> `pll_reset` is high for 4 cycles and `sys_reset` falls 3+8 cycles after the `pll_lock` rise. `locked`=1, `retry_cnt`=0.
- **Timeout retry.** Hold `pll_lock`=0 -> `pll_reset` re-pulses every 4+20 cycles and `retry_cnt` reads 1, then 2.
- **Unstable lock.** Raise `pll_lock` for 5 cycles, drop it, then raise it permanently -> no release after the first rise. Release happens 8 cycles after re-entering STABLE. `retry_cnt` is unchanged.
- **Lock loss in RUN.** Drop `pll_lock` -> `sys_reset`=1 and `pll_reset`=1 within 3 cycles and `lock_lost`=1. Pulse `clr_status` -> `lock_lost`=0.
- **Retry limit** (macro defined). Never assert lock -> after the third timeout `fail`=1 and `pll_reset` stays high. With the macro undefined, `fail` stays 0 and retries continue.
- **Async reset mid-STABLE.** Assert `reset` between edges -> outputs take their reset values immediately, with no clock edge needed.
